vca: RTL
========

# vca

Voltage-controlled amplifier stage that sits directly downstream of the envelope generator. Once per sample-rate strobe it latches an oscillator sample and the current envelope accumulator and multiplies them with a bit-serial shift-add multiplier. It presents the amplitude-scaled sample to the mixer/DAC stage with a one-cycle valid pulse. One VCA instance serves one voice.

## Interface
**Parameters**
- `SAMPLE_WIDTH`, 16: width of the signed two's-complement audio sample, in and out.
- `ENV_BITS`, 24: width of the envelope accumulator input.
- `GAIN_BITS`, 16: number of envelope MSBs used as gain. Must be ≤ `ENV_BITS`.

**Ports**
- `clk`, in, 1: master clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `sample_stb`, in, 1: one-`clk` strobe at the sample rate (`low_clk` domain pulse, already synchronous to `clk`).
- `sample_in`, in, `SAMPLE_WIDTH`: signed oscillator sample.
- `env_in`, in, `ENV_BITS`: unsigned envelope level (envelope generator `signal_out`).
- `sample_out`, out, `SAMPLE_WIDTH`: signed scaled sample. Held between results.
- `out_valid`, out, 1: one-cycle pulse when `sample_out` updates.
- `busy`, out, 1: multiply in progress.
- `dropped`, out, 1: sticky; set when a strobe arrives while busy. Cleared only by reset.

## Operation
- Gain `g = env_in[ENV_BITS-1 -: GAIN_BITS]`, unsigned fraction `g / 2^GAIN_BITS`.
- States: IDLE, MUL.
  - **IDLE, `sample_stb`=1:** latch `sample_in` into the multiplicand, sign-extended to `SAMPLE_WIDTH+GAIN_BITS+1`. Latch `g`. Set `full = (g == all-ones)`. Clear the accumulator. Set `bit_cnt = 0`. Go to MUL.
  - **MUL:** each cycle, if `g[bit_cnt]` then `acc += multiplicand << bit_cnt`. Then increment `bit_cnt`.
  - **Last MUL cycle (`bit_cnt = GAIN_BITS-1`):** the final accumulate is included. `sample_out <= full ? latched sample : (acc_final >>> GAIN_BITS)[SAMPLE_WIDTH-1:0]`. `out_valid <= 1`. Go to IDLE.
- Arithmetic right shift means the result rounds toward −∞. No saturation is needed because |result| ≤ |sample|.
- `full` bypass makes the maximum envelope unity gain, giving an exact pass-through.
- `g = 0` yields 0 through the normal path.
- A strobe in MUL is ignored and `dropped <= 1`. The in-flight multiply is unaffected.
- Inputs are sampled only on the accepting edge. Later changes to `sample_in` or `env_in` do not affect the current result.

## Timing
- Reset values: `sample_out = 0`, `out_valid = 0`, `busy = 0`, `dropped = 0`, state IDLE. Asserting `rst` mid-multiply aborts it immediately; no `out_valid` follows.
- Strobe accepted at edge E0. `busy` is high from E0 through E`GAIN_BITS`. `sample_out` and `out_valid` update at edge E`GAIN_BITS`. Latency is `GAIN_BITS` clocks (16 at default).
- `out_valid` is high exactly one cycle. `busy` is low in that same cycle.
- A strobe coinciding with the `out_valid` cycle is accepted, because state is IDLE. Minimum strobe spacing is `GAIN_BITS` clocks. At 50 MHz / 48 kHz the spacing is about 1041 clocks.

## Structure
- Shared package `vca_pkg`: state encoding (IDLE = 1'b0, MUL = 1'b1) and width helper constants (`PROD_WIDTH = SAMPLE_WIDTH+GAIN_BITS+1`).
- One sub-module, `serial_mult`, holds the signed × unsigned shift-add core. It has start/done, operands and product ports.
- `vca` owns strobe acceptance, gain extraction, the bypass, output registers and `dropped`.

## Test plan
- Reset then idle: no strobe → `sample_out = 0`, `out_valid` never asserts, `busy = 0`.
- Half gain, both signs:
  - `sample_in = 16384`, `env_in = 24'h800000`, strobe → after 16 clocks `sample_out = 8192`, `out_valid` pulses for 1 cycle.
  - Repeat with `sample_in = -16384` → `-8192`.
- Rounding: `sample_in = -1`, `env_in = 24'h800000` → `sample_out = -1`. `sample_in = 1` → `0`.
- Bounds:
  - `env_in = 24'h000000` with `sample_in = -32768` → `0`.
  - `env_in = 24'hFFFF00` with `sample_in = -32768` → `-32768` (bypass).
- Overlap: second strobe 5 clocks after the first → first result correct, no second `out_valid`, `dropped = 1`. A strobe in the `out_valid` cycle is accepted, and its result appears 16 clocks later.
- Reset mid-op: deassert-assert `rst` 8 clocks after a strobe → outputs return to 0 and `busy = 0`. No `out_valid` follows. The next strobe works normally.

Source files
------------

// File: rtl/vca_pkg.sv
// vca_pkg: shared types and width helpers for the voltage-controlled amplifier.
//   vca_state_e : control FSM encoding (StIdle = 0, StMul = 1)
//   prod_width(): width of the signed shift-add product for given sample/gain widths
package vca_pkg;

   localparam int unsigned SAMPLE_WIDTH_DFLT = 16;
   localparam int unsigned ENV_BITS_DFLT     = 24;
   localparam int unsigned GAIN_BITS_DFLT    = 16;
   localparam int unsigned PROD_WIDTH        = SAMPLE_WIDTH_DFLT + GAIN_BITS_DFLT + 1;

   typedef enum logic {
      StIdle = 1'b0,
      StMul  = 1'b1
   } vca_state_e;

   function automatic int unsigned prod_width(input int unsigned sample_width,
                                              input int unsigned gain_bits);
      return sample_width + gain_bits + 1;
   endfunction

endpackage

// File: rtl/vca_if.sv
// vca_if: sample/envelope input and scaled-sample output bundle of one VCA voice.
//   master : drives sample_stb, sample_in, env_in; observes results and status
//   slave  : the VCA itself
interface vca_if
   import vca_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DFLT,
   parameter int unsigned ENV_BITS     = ENV_BITS_DFLT
);
   logic                           sample_stb;
   logic signed [SAMPLE_WIDTH-1:0] sample_in;
   logic        [ENV_BITS-1:0]     env_in;
   logic signed [SAMPLE_WIDTH-1:0] sample_out;
   logic                           out_valid;
   logic                           busy;
   logic                           dropped;

   modport master (
      output sample_stb, sample_in, env_in,
      input  sample_out, out_valid, busy, dropped
   );

   modport slave (
      input  sample_stb, sample_in, env_in,
      output sample_out, out_valid, busy, dropped
   );
endinterface

// File: rtl/vca_serial_mult.sv
// vca_serial_mult: signed x unsigned shift-add multiplier, one multiplier bit per clock.
//   clk, rst       : clock, async active-low reset
//   start_i        : latch operands and begin (ignored while running)
//   multiplicand_i : signed sample
//   multiplier_i   : unsigned gain
//   done_o         : high during the last add cycle; product_o is valid then
//   product_o      : final product including that cycle's add
module vca_serial_mult
   import vca_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DFLT,
   parameter int unsigned GAIN_BITS    = GAIN_BITS_DFLT
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start_i,
   input  logic signed [SAMPLE_WIDTH-1:0]          multiplicand_i,
   input  logic        [GAIN_BITS-1:0]             multiplier_i,
   output logic                                    done_o,
   output logic signed [SAMPLE_WIDTH+GAIN_BITS:0]  product_o
);
   localparam int unsigned PW = prod_width(SAMPLE_WIDTH, GAIN_BITS);
   localparam int unsigned CW = (GAIN_BITS > 1) ? $clog2(GAIN_BITS) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(GAIN_BITS - 1);

   logic signed [PW-1:0]        mcand_q;
   logic signed [PW-1:0]        acc_q;
   logic signed [PW-1:0]        acc_d;
   logic signed [PW-1:0]        addend;
   logic        [GAIN_BITS-1:0] mplier_q;
   logic        [CW-1:0]        cnt_q;
   logic                        run_q;

   always_comb begin
      addend = '0;
      if (mplier_q[cnt_q]) begin
         addend = mcand_q <<< cnt_q;
      end
      acc_d = acc_q + addend;
   end

   // Product is taken from acc_d so the final partial product is not lost a cycle.
   assign done_o    = run_q && (cnt_q == LastCnt);
   assign product_o = acc_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (start_i && !run_q) begin
         mcand_q  <= {{(PW - SAMPLE_WIDTH){multiplicand_i[SAMPLE_WIDTH-1]}}, multiplicand_i};
         acc_q    <= '0;
         mplier_q <= multiplier_i;
         cnt_q    <= '0;
         run_q    <= 1'b1;
      end else if (run_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) begin
            run_q <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/vca.sv
// vca: one-voice voltage-controlled amplifier. On sample_stb (while idle) latches the
// sample and the top GAIN_BITS of the envelope, multiplies serially, and presents
// sample * g / 2^GAIN_BITS (floored) with a one-cycle out_valid pulse.
//   clk, rst : clock, async active-low reset
//   bus      : vca_if slave (sample_stb/sample_in/env_in in; sample_out/out_valid/busy/dropped out)
module vca
   import vca_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DFLT,
   parameter int unsigned ENV_BITS     = ENV_BITS_DFLT,
   parameter int unsigned GAIN_BITS    = GAIN_BITS_DFLT
) (
   input logic  clk,
   input logic  rst,
   vca_if.slave bus
);
   localparam int unsigned PW = prod_width(SAMPLE_WIDTH, GAIN_BITS);

   vca_state_e                     state_q;
   logic signed [SAMPLE_WIDTH-1:0] sample_q;
   logic                           full_q;
   logic signed [SAMPLE_WIDTH-1:0] sample_out_q;
   logic                           out_valid_q;
   logic                           busy_q;
   logic                           dropped_q;

   logic        [GAIN_BITS-1:0]    gain;
   logic                           mult_start;
   logic                           mult_done;
   logic signed [PW-1:0]           product;

   assign gain       = bus.env_in[ENV_BITS-1 -: GAIN_BITS];
   assign mult_start = (state_q == StIdle) && bus.sample_stb;

   // Envelope LSBs below the gain field and the product guard/fraction bits are unused.
   logic unused_prod;
   assign unused_prod = ^{product[PW-1], product[GAIN_BITS-1:0]};
   if (ENV_BITS > GAIN_BITS) begin : g_env_lo
      logic unused_env_lo;
      assign unused_env_lo = ^bus.env_in[ENV_BITS-GAIN_BITS-1:0];
   end

   vca_serial_mult #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .GAIN_BITS    (GAIN_BITS)
   ) u_mult (
      .clk            (clk),
      .rst            (rst),
      .start_i        (mult_start),
      .multiplicand_i (bus.sample_in),
      .multiplier_i   (gain),
      .done_o         (mult_done),
      .product_o      (product)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         sample_q     <= '0;
         full_q       <= 1'b0;
         sample_out_q <= '0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         dropped_q    <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.sample_stb) begin
                  sample_q <= bus.sample_in;
                  // All-ones gain is treated as exact unity rather than (2^N-1)/2^N.
                  full_q   <= &gain;
                  busy_q   <= 1'b1;
                  state_q  <= StMul;
               end
            end
            StMul: begin
               if (bus.sample_stb) begin
                  dropped_q <= 1'b1;
               end
               if (mult_done) begin
                  sample_out_q <= full_q ? sample_q : product[GAIN_BITS +: SAMPLE_WIDTH];
                  out_valid_q  <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= StIdle;
               end
            end
         endcase
      end
   end

   assign bus.sample_out = sample_out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = busy_q;
   assign bus.dropped    = dropped_q;
endmodule
